// File: rtl/parking_occupancy_counter.sv
// Two-beam gate occupancy counter: synchronize and debounce both sensors, decode
// the crossing order, keep a two-digit BCD count. Optional macro FULL_DASH_EN shows "--" when full.
module parking_occupancy_counter #(
  parameter int CAPACITY        = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       reject_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] CAP_TENS = 4'(CAPACITY / 10);
  localparam logic [3:0] CAP_ONES = 4'(CAPACITY % 10);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EN1        = 3'd1,
    EN2        = 3'd2,
    EN3        = 3'd3,
    EX1        = 3'd4,
    EX2        = 3'd5,
    EX3        = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  // Index 1 is sensor A (outer), index 0 is sensor B (inner).
  logic [1:0]    meta_q;
  logic [1:0]    sync_q;
  logic [1:0]    filt_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    filt_d;

  state_t     state_q;
  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       enter_q;
  logic       exit_q;
  logic       reject_q;
  logic [1:0] ab_s;
  logic       full_s;
  logic       empty_s;

  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, ones + 4'd1};
    end
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd0) begin
      return {tens - 4'd1, 4'd9};
    end else begin
      return {tens, ones - 4'd1};
    end
  endfunction

  // Two-flop synchronizers for the asynchronous beam inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {sensor_a, sensor_b};
      sync_q <= meta_q;
    end
  end

  // Filter flips only on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        filt_d[i] = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q   <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign ab_s    = filt_q;
  assign full_s  = (tens_q == CAP_TENS) && (ones_q == CAP_ONES);
  assign empty_s = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Crossing-order FSM with the BCD count and strobes updated on the return to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          case (ab_s)
            2'b10:   state_q <= EN1;
            2'b01:   state_q <= EX1;
            2'b11:   state_q <= WAIT_CLEAR;
            default: state_q <= IDLE;
          endcase
        end
        EN1: begin
          case (ab_s)
            2'b10:   state_q <= EN1;
            2'b11:   state_q <= EN2;
            2'b00:   state_q <= IDLE;
            default: state_q <= WAIT_CLEAR;
          endcase
        end
        EN2: begin
          case (ab_s)
            2'b11:   state_q <= EN2;
            2'b01:   state_q <= EN3;
            2'b10:   state_q <= EN1;
            default: state_q <= WAIT_CLEAR;
          endcase
        end
        EN3: begin
          case (ab_s)
            2'b01: state_q <= EN3;
            2'b11: state_q <= EN2;
            2'b00: begin
              state_q <= IDLE;
              if (full_s) begin
                reject_q <= 1'b1;
              end else begin
                {tens_q, ones_q} <= bcd_inc(tens_q, ones_q);
                enter_q          <= 1'b1;
              end
            end
            default: state_q <= WAIT_CLEAR;
          endcase
        end
        EX1: begin
          case (ab_s)
            2'b01:   state_q <= EX1;
            2'b11:   state_q <= EX2;
            2'b00:   state_q <= IDLE;
            default: state_q <= WAIT_CLEAR;
          endcase
        end
        EX2: begin
          case (ab_s)
            2'b11:   state_q <= EX2;
            2'b10:   state_q <= EX3;
            2'b01:   state_q <= EX1;
            default: state_q <= WAIT_CLEAR;
          endcase
        end
        EX3: begin
          case (ab_s)
            2'b10: state_q <= EX3;
            2'b11: state_q <= EX2;
            2'b00: begin
              state_q <= IDLE;
              if (empty_s) begin
                reject_q <= 1'b1;
              end else begin
                {tens_q, ones_q} <= bcd_dec(tens_q, ones_q);
                exit_q           <= 1'b1;
              end
            end
            default: state_q <= WAIT_CLEAR;
          endcase
        end
        WAIT_CLEAR: begin
          if (ab_s == 2'b00) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT_CLEAR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full         = full_s;
  assign empty        = empty_s;
  assign enter_pulse  = enter_q;
  assign exit_pulse   = exit_q;
  assign reject_pulse = reject_q;

`ifdef FULL_DASH_EN
  assign digit1 = full_s ? 4'hF : ones_q;
  assign digit2 = full_s ? 4'hF : tens_q;
`else
  assign digit1 = ones_q;
  assign digit2 = tens_q;
`endif

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for parking_occupancy_counter with CAPACITY=12, DEBOUNCE_CYCLES=4.
// Pulses are tallied by a monitor; every comparison goes through the check task.
module tb_parking_occupancy_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       sensor_a;
  logic       sensor_b;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic       full;
  logic       empty;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       reject_pulse;

  int checks = 0;
  int errors = 0;
  int n_enter = 0;
  int n_exit = 0;
  int n_reject = 0;

`ifdef FULL_DASH_EN
  localparam logic [3:0] FULL_ONES = 4'hF;
  localparam logic [3:0] FULL_TENS = 4'hF;
`else
  localparam logic [3:0] FULL_ONES = 4'd2;
  localparam logic [3:0] FULL_TENS = 4'd1;
`endif

  parking_occupancy_counter #(
    .CAPACITY       (12),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .digit1      (digit1),
    .digit2      (digit2),
    .full        (full),
    .empty       (empty),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .reject_pulse(reject_pulse)
  );

  always #5 clock = ~clock;

  // Tally strobes just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (enter_pulse)  n_enter++;
    if (exit_pulse)   n_exit++;
    if (reject_pulse) n_reject++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic car_in();
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b1, 8);
    hold(1'b0, 1'b0, 8);
  endtask

  task automatic car_out();
    hold(1'b0, 1'b1, 8);
    hold(1'b1, 1'b1, 8);
    hold(1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 8);
  endtask

  task automatic check_digits(input string tag, input logic [3:0] tens, input logic [3:0] ones);
    check({tag, "_tens"}, {28'd0, digit2}, {28'd0, tens});
    check({tag, "_ones"}, {28'd0, digit1}, {28'd0, ones});
  endtask

  initial begin
    int e0, x0, r0;
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(negedge clock);
    check_digits("reset", 4'd0, 4'd0);
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_pulses", {29'd0, enter_pulse, exit_pulse, reject_pulse}, 32'd0);
    reset = 1'b0;
    hold(1'b0, 1'b0, 4);

    // First entry
    e0 = n_enter;
    car_in();
    check("entry1_pulses", n_enter - e0, 32'd1);
    check_digits("entry1", 4'd0, 4'd1);
    check("entry1_empty", {31'd0, empty}, 32'd0);

    // Exit, then exit while empty
    x0 = n_exit; r0 = n_reject;
    car_out();
    check("exit1_pulses", n_exit - x0, 32'd1);
    check_digits("exit1", 4'd0, 4'd0);
    check("exit1_empty", {31'd0, empty}, 32'd1);
    car_out();
    check("exit_empty_reject", n_reject - r0, 32'd1);
    check("exit_empty_no_exit", n_exit - x0, 32'd1);
    check_digits("exit_empty", 4'd0, 4'd0);

    // Ten entries across the BCD carry, then a borrow
    e0 = n_enter;
    for (int i = 0; i < 9; i++) car_in();
    check_digits("nine", 4'd0, 4'd9);
    car_in();
    check_digits("ten", 4'd1, 4'd0);
    check("ten_pulses", n_enter - e0, 32'd10);
    car_out();
    check_digits("borrow", 4'd0, 4'd9);

    // Fill to capacity and reject one more
    for (int i = 0; i < 3; i++) car_in();
    check("full_flag", {31'd0, full}, 32'd1);
    check_digits("full", FULL_TENS, FULL_ONES);
    e0 = n_enter; r0 = n_reject;
    car_in();
    check("full_reject", n_reject - r0, 32'd1);
    check("full_no_enter", n_enter - e0, 32'd0);
    check("full_still", {31'd0, full}, 32'd1);
    car_out();
    check_digits("after_full_exit", 4'd1, 4'd1);
    check("after_full_flag", {31'd0, full}, 32'd0);

    // Short glitch, then a backed-out car
    e0 = n_enter; x0 = n_exit; r0 = n_reject;
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 8);
    hold(1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 8);
    check("backup_pulses", (n_enter - e0) + (n_exit - x0) + (n_reject - r0), 32'd0);
    check_digits("backup", 4'd1, 4'd1);

    // Reset while in EN2 with both beams still blocked
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 8);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_digits("midreset", 4'd0, 4'd0);
    check("midreset_empty", {31'd0, empty}, 32'd1);
    e0 = n_enter; x0 = n_exit; r0 = n_reject;
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 10);
    check("midreset_pulses", (n_enter - e0) + (n_exit - x0) + (n_reject - r0), 32'd0);
    check_digits("midreset_after", 4'd0, 4'd0);
    car_in();
    check("post_reset_entry", n_enter - e0, 32'd1);
    check_digits("post_reset", 4'd0, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
- Tracks how many cars are inside the lot, using two beam-break sensors at the gate (A outer, B inner).
- Synchronizes and debounces both sensors, then decodes the entry/exit crossing order with an FSM.
- Keeps the occupancy directly in two BCD digits.
- Produces the ones/tens digit values that the board's two-digit seven-segment display driver consumes.

Parameters:
- CAPACITY, 20: maximum occupancy; legal range 1..99.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed before a filtered sensor changes (10 ms at 100 MHz).

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- sensor_a, input, 1: raw outer beam, 1 = blocked; asynchronous to clock.
- sensor_b, input, 1: raw inner beam, 1 = blocked; asynchronous to clock.
- digit1, output, 4: BCD ones digit of occupancy (0..9).
- digit2, output, 4: BCD tens digit of occupancy (0..9).
- full, output, 1: high when occupancy == CAPACITY.
- empty, output, 1: high when occupancy == 0.
- enter_pulse, output, 1: one-cycle strobe when an entry is counted.
- exit_pulse, output, 1: one-cycle strobe when an exit is counted.
- reject_pulse, output, 1: one-cycle strobe when a completed crossing cannot be counted (entry while full, exit while empty).

Behaviour:
- Reset values: digit1=0, digit2=0, empty=1, full=0, all pulses=0, FSM=IDLE, synchronizer and filter flops=0, debounce counters=0.
- Input conditioning:
  - Each sensor passes through a 2-flop synchronizer.
  - Its filtered value (fa, fb) changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle clears that sensor's debounce counter.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLEAR. All transitions below key on the pair {fa,fb}.
- From IDLE:
  - 10 -> EN1.
  - 01 -> EX1.
  - 11 -> WAIT_CLEAR.
  - 00 -> stay.
- Entry sequence:
  - EN1: 11 -> EN2; 00 -> IDLE (abort); 01 -> WAIT_CLEAR.
  - EN2: 01 -> EN3; 10 -> EN1 (back-up).
  - EN3: 00 -> IDLE with an entry event; 11 -> EN2 (back-up); 10 -> WAIT_CLEAR.
- Exit sequence: mirror of the entry sequence with a and b swapped (EX1 = 01, EX2 = 11, EX3 = 10); EX3 with 00 -> IDLE with an exit event.
- Any unlisted pattern -> WAIT_CLEAR. WAIT_CLEAR leaves to IDLE only on 00, and no event is produced.
- An unchanged pattern keeps the current state.
- Count update:
  - The registered update takes effect on the clock edge at which the FSM returns to IDLE. The strobe is high during the same cycle that the new digits first appear.
  - Entry, occupancy < CAPACITY: increment; ones 9 wraps to 0 and carries into tens; enter_pulse=1.
  - Entry when full: count unchanged; reject_pulse=1.
  - Exit, occupancy > 0: decrement; ones 0 borrows, giving 9 and tens-1; exit_pulse=1.
  - Exit when empty: count unchanged; reject_pulse=1.
- full and empty are combinational from the registered digits. Tens digit is never above 9.
- At most one event can occur per cycle, so simultaneous enter/exit is impossible by construction.
- Reset mid-crossing: the car is lost, the FSM returns to IDLE and the count returns to 0.
  - If sensors are still blocked after reset, the filters rise after DEBOUNCE_CYCLES.
  - Seeing 11 from IDLE sends the FSM to WAIT_CLEAR, so no spurious count.

Optional Feature:
- Macro: FULL_DASH_EN.
- Defined: while full=1, digit1 and digit2 are both driven to 4'hF, so the display shows "--". enter_pulse, exit_pulse, reject_pulse and the internal count are unaffected; real digits return on the first exit.
- Undefined: digit1 and digit2 always show the BCD occupancy.

Test Plan:
- Bench configuration for all scenarios: DEBOUNCE_CYCLES=4, CAPACITY=12.
- Reset, then hold A=1 for 8 cycles, A=B=1 for 8, B=1 for 8, both 0 for 8 -> one enter_pulse; digit2=0, digit1=1; empty goes 1->0.
- From occupancy 1, run the exit order B, AB, A, none -> one exit_pulse; digits=0,0; empty=1. Repeat the exit -> reject_pulse, digits stay 0,0.
- Apply 10 entries -> digits go from 0,9 to 1,0 on the 10th enter_pulse. Then one exit -> 0,9.
- Reach 12 -> full=1 (digits 4'hF,4'hF if FULL_DASH_EN). A 13th entry -> reject_pulse; the count stays 12.
- Glitch test: A pulse of 2 cycles -> no state change. Backing up A, AB, A, none -> no pulse, count unchanged.
- Assert reset while in EN2 with A=B=1 held -> digits 0,0, FSM goes IDLE then WAIT_CLEAR. Then release both sensors -> no pulse.
